countdown_timer_9bit: RTL and testbench

9-bit loadable down-counter/timer: the counting-down complement of the up-counter family (`counter_9bit`). It lets the design time intervals in clock cycles instead of accumulating events. Software or a controlling FSM loads a count, starts it, and observes a single-cycle terminal-count pulse plus a sticky done flag. It sits beside the up-counters on the same `clk`, using the same `en`/`clr` control style.

---
 rtl/ctr_pkg.sv | 14 +
 rtl/down_ctr_core.sv | 39 +++
 rtl/countdown_timer_9bit.sv | 109 ++++++++++
 tb/tb_countdown_timer_9bit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctr_pkg.sv
// ctr_pkg: definitions shared by the counter family (up-counters and countdown timer).
//   - CtrDefaultWidth : default counter width.
//   - ctr_state_e     : timer FSM encoding (IDLE=0, RUN=1, DONE=2).
package ctr_pkg;

    localparam int unsigned CtrDefaultWidth = 9;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } ctr_state_e;

endpackage

// File: rtl/down_ctr_core.sv
// down_ctr_core: WIDTH-bit down-counting register.
// Ports:
//   clk_i        rising-edge clock
//   clr_i        synchronous active-high clear (highest priority)
//   load_i       load load_val_i into the counter
//   load_val_i   value to load
//   dec_i        decrement request; saturates at zero (never wraps)
//   cnt_o        current count
//   zero_next_o  high when a decrement this cycle takes the count from 1 to 0
module down_ctr_core
    import ctr_pkg::*;
#(
    parameter int unsigned WIDTH = CtrDefaultWidth
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             zero_next_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign cnt_o       = cnt_q;
    assign zero_next_o = dec_i && (cnt_q == WIDTH'(1));

endmodule

// File: rtl/countdown_timer_9bit.sv
// countdown_timer_9bit: loadable down-counter/timer with terminal-count pulse and sticky done.
// Ports:
//   clk_i       rising-edge clock
//   clr_i       synchronous active-high clear, overrides everything
//   en_i        count enable (pause when low in RUN)
//   load_i      write load_val_i into count and reload register, go IDLE
//   load_val_i  value to load
//   start_i     start/restart from the current count (ignored in RUN)
//   cout_o      current count
//   busy_o      high in RUN
//   tc_o        one-cycle pulse on the edge the count reaches 0 by counting
//   done_o      high in DONE
// Build option: define COUNTDOWN_AUTO_RELOAD_EN for periodic operation; on the enabled cycle
// after a terminal step the count is refilled from the reload register (DONE if it is zero).
module countdown_timer_9bit
    import ctr_pkg::*;
#(
    parameter int unsigned WIDTH = CtrDefaultWidth
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] cout_o,
    output logic             busy_o,
    output logic             tc_o,
    output logic             done_o
);

    ctr_state_e       state_q;
    logic [WIDTH-1:0] reload_q;
    logic             tc_q;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] core_val;
    logic             core_load;
    logic             run_en;
    logic             cnt_zero;
    logic             zero_next;
    logic             reload_evt;

    assign run_en   = (state_q == StRun) && en_i;
    assign cnt_zero = (cnt == '0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // RUN at zero only occurs after a terminal step in periodic mode.
    assign reload_evt = run_en && cnt_zero && (reload_q != '0);
`else
    assign reload_evt = 1'b0;
`endif

    // An external load always wins over the internal refill.
    assign core_load = load_i | reload_evt;
    assign core_val  = load_i ? load_val_i : reload_q;

    down_ctr_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk_i      (clk_i),
        .clr_i      (clr_i),
        .load_i     (core_load),
        .load_val_i (core_val),
        .dec_i      (run_en),
        .cnt_o      (cnt),
        .zero_next_o(zero_next)
    );

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q  <= StIdle;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else if (load_i) begin
            state_q  <= StIdle;
            reload_q <= load_val_i;
            tc_q     <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        state_q <= cnt_zero ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (en_i) begin
                        if (zero_next) begin
                            tc_q <= 1'b1;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
                            state_q <= StDone;
`endif
                        end else if (cnt_zero && (reload_q == '0)) begin
                            state_q <= StDone;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cout_o = cnt;
    assign busy_o = (state_q == StRun);
    assign done_o = (state_q == StDone);
    assign tc_o   = tc_q;

endmodule

// File: tb/tb_countdown_timer_9bit.sv
// Self-checking bench for countdown_timer_9bit: a behavioural timer model is compared with the
// DUT on every falling edge, plus directed sequences with hand-computed expectations.
module tb_countdown_timer_9bit;

    localparam int W = 9;
    localparam int MIdle = 0;
    localparam int MRun  = 1;
    localparam int MDone = 2;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic [W-1:0] cout;
    logic         busy;
    logic         tc;
    logic         done;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    int m_cnt = 0;
    int m_rel = 0;
    int m_mode = MIdle;
    bit m_tc = 1'b0;
    bit prev_tc = 1'b0;

    always #5 clk = ~clk;

    countdown_timer_9bit dut (
        .clk_i     (clk),
        .clr_i     (clr),
        .en_i      (en),
        .load_i    (load),
        .load_val_i(load_val),
        .start_i   (start),
        .cout_o    (cout),
        .busy_o    (busy),
        .tc_o      (tc),
        .done_o    (done)
    );

    // Model: inputs are changed on the falling edge, so they are stable here.
    always @(posedge clk) begin
        if (clr) begin
            m_cnt = 0; m_rel = 0; m_mode = MIdle; m_tc = 1'b0;
        end else if (load) begin
            m_cnt = int'(load_val); m_rel = int'(load_val); m_mode = MIdle; m_tc = 1'b0;
        end else begin
            m_tc = 1'b0;
            if (m_mode != MRun) begin
                if (start) m_mode = (m_cnt == 0) ? MDone : MRun;
            end else if (en) begin
                if (m_cnt > 1) begin
                    m_cnt = m_cnt - 1;
                end else if (m_cnt == 1) begin
                    m_cnt = 0;
                    m_tc = 1'b1;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
                    m_mode = MDone;
`endif
                end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (m_rel == 0) m_mode = MDone;
                    else m_cnt = m_rel;
`else
                    m_mode = MDone;
`endif
                end
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process against the model.
    always @(negedge clk) begin
        if (check_en) begin
            cmp("model_cout", int'(cout), m_cnt);
            cmp("model_busy", int'(busy), int'(m_mode == MRun));
            cmp("model_done", int'(done), int'(m_mode == MDone));
            cmp("model_tc", int'(tc), int'(m_tc));
            cmp("tc_not_consecutive", int'(prev_tc && tc), 0);
        end
        prev_tc = tc;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = W'(v); start = 1'b0;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start(input bit e);
        start = 1'b1; en = e;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        int n;
        int tc_seen;
        bit [5:0] en_pat;
        int exp_seq[6];

        cyc();
        clr = 1'b1; en = 1'b1;
        cyc(); cyc();
        check_en = 1'b1;
        cmp("rst_cout", int'(cout), 0);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_tc", int'(tc), 0);
        cmp("rst_done", int'(done), 0);
        clr = 1'b0; en = 1'b0;

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // Load 5, start, count 5..0
        do_load(5);
        do_start(1'b1);
        cmp("l5_start_cout", int'(cout), 5);
        cmp("l5_start_busy", int'(busy), 1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            cmp("l5_cout", int'(cout), 5 - i);
            cmp("l5_tc", int'(tc), int'(i == 5));
        end
        cmp("l5_done", int'(done), 1);
        cyc();
        cmp("l5_done_hold", int'(done), 1);
        cmp("l5_tc_low", int'(tc), 0);
        cmp("l5_cout_hold", int'(cout), 0);

        // Load 4, pause pattern
        do_load(4);
        do_start(1'b0);
        en_pat = 6'b111001;  // applied LSB first: 1,0,0,1,1,1
        exp_seq = '{3, 3, 3, 2, 1, 0};
        tc_seen = 0;
        for (int k = 0; k < 6; k++) begin
            en = en_pat[k];
            cyc();
            cmp("pause_cout", int'(cout), exp_seq[k]);
            tc_seen += int'(tc);
        end
        cmp("pause_tc_once", tc_seen, 1);

        // Load 0, start -> DONE, no tc
        do_load(0);
        do_start(1'b1);
        cmp("zero_done", int'(done), 1);
        cmp("zero_tc", int'(tc), 0);

        // Load 511: tc after 511 enabled cycles
        do_load(511);
        do_start(1'b1);
        n = 0;
        while (!tc && n < 600) begin
            cyc();
            n++;
        end
        cmp("max_cycles", n, 511);
`else
        // Periodic: load 2 -> 1,0,2,1,0,2 with tc at zeros
        do_load(2);
        do_start(1'b1);
        exp_seq = '{1, 0, 2, 1, 0, 2};
        for (int k = 0; k < 6; k++) begin
            cyc();
            cmp("auto_cout", int'(cout), exp_seq[k]);
            cmp("auto_tc", int'(tc), int'(exp_seq[k] == 0));
            cmp("auto_done", int'(done), 0);
        end
`endif

        // Load during RUN together with start: load wins
        do_load(6);
        do_start(1'b1);
        cyc(); cyc(); cyc();
        cmp("abort_pre_cout", int'(cout), 3);
        load = 1'b1; load_val = W'(2); start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        cmp("abort_busy", int'(busy), 0);
        cmp("abort_cout", int'(cout), 2);
        cmp("abort_tc", int'(tc), 0);
        do_start(1'b1);
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        cmp("clr_cout", int'(cout), 0);
        cmp("clr_busy", int'(busy), 0);
        cmp("clr_done", int'(done), 0);

        // Randomized phase against the model
        for (int i = 0; i < 3000; i++) begin
            clr   = ($urandom_range(63) == 0);
            load  = ($urandom_range(15) == 0);
            start = ($urandom_range(7) == 0);
            en    = ($urandom_range(3) != 0);
            load_val = ($urandom_range(3) == 0) ? W'($urandom) : W'($urandom_range(12));
            cyc();
        end
        clr = 1'b0; load = 1'b0; start = 1'b0; en = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
